bin_scheduler: RTL and testbench
================================

Name: bin_scheduler

Overview:
Top-level bin sequencing controller directly upstream of the bin load/update stage.
- Selects which clause/variable bin is loaded next and drives the load/update start handshake.
- Launches the bin SAT engine and consumes its per-bin result.
- On conflict, starts global var-state backtrack and redirects to the backtrack bin.
- Reports final SAT/UNSAT.

Parameters:
NUM_BINS, 32, number of bins in the problem image (2..2^WIDTH_BIN_I)
WIDTH_BIN_I, 10, bin index width
WIDTH_LVL, 10, decision level width
TIMEOUT_CYCLES, 65535, watchdog limit per wait state (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset
start_i  in  1  pulse: begin solving from bin 0
start_load_update_o  out  1  one-cycle pulse to load/update stage
first_load_update_o  out  1  high with that pulse only for the first load after start_i (nothing to write back)
request_bin_num_o  out  WIDTH_BIN_I  bin to load; stable from pulse until load_update_done_i
load_update_done_i  in  1  load/update stage finished
start_bin_solve_o  out  1  one-cycle pulse to bin SAT engine
bin_solve_done_i  in  1  engine result valid (single cycle)
bin_result_i  in  2  0=bin SAT, 1=conflict, 2=global UNSAT, 3=reserved (treated as 2)
bkt_lvl_i  in  WIDTH_LVL  backtrack level, sampled with bin_solve_done_i
bkt_bin_i  in  WIDTH_BIN_I  bin to resume at, sampled with bin_solve_done_i
start_backtrack_o  out  1  one-cycle pulse
bkt_lvl_o  out  WIDTH_LVL  captured level; held through the backtrack
backtrack_done_i  in  1  backtrack finished
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at finish
sat_o  out  1  held until next start_i
unsat_o  out  1  held until next start_i
conflict_cnt_o  out  32  conflicts since start_i; saturates at all-ones
timeout_o  out  1  watchdog fired; held until next start_i (tied 0 without the feature)

Behaviour:
- Reset is synchronous, active-low; clock is clk.
- While rst=0 at a clk edge: state=IDLE; all outputs and internal registers 0, including the bin pointer and conflict_cnt_o.
- FSM states: IDLE, LOAD, WAIT_LOAD, SOLVE, WAIT_SOLVE, BKT, WAIT_BKT, FINISH.
- IDLE
  - start_i → LOAD.
  - cur_bin=0, first flag=1.
  - sat_o, unsat_o, timeout_o, conflict_cnt_o cleared.
  - start_i sampled at edge N produces start_load_update_o high in cycle N+1.
- LOAD
  - start_load_update_o=1; first_load_update_o=first flag; request_bin_num_o=cur_bin.
  - Clear first flag; → WAIT_LOAD.
- WAIT_LOAD: load_update_done_i → SOLVE. A done arriving in the same cycle as the LOAD pulse is ignored.
- SOLVE: start_bin_solve_o=1 for one cycle; → WAIT_SOLVE.
- WAIT_SOLVE, on bin_solve_done_i:
  - result 0, cur_bin==NUM_BINS-1: sat_o=1 → FINISH.
  - result 0, otherwise: cur_bin+1 → LOAD.
  - result 1, bkt_lvl_i==0: unsat_o=1 → FINISH; no backtrack pulse; conflict count still incremented.
  - result 1, bkt_lvl_i≠0: capture bkt_lvl_o; target = min(bkt_bin_i, cur_bin); increment count → BKT.
  - result 2 or 3: unsat_o=1 → FINISH.
- BKT: start_backtrack_o=1 for one cycle; → WAIT_BKT.
- WAIT_BKT: backtrack_done_i → cur_bin=target → LOAD. first_load_update_o stays 0.
- FINISH: done_o=1 for one cycle; → IDLE.
- Handshake inputs outside their wait state are ignored. start_i while busy is ignored.
- Reset mid-operation aborts immediately; no pulse is emitted on the cycle after reset.

Optional Feature:
Macro BIN_SCHED_WATCHDOG_EN.
- Defined:
  - A 32-bit counter clears on entry to WAIT_LOAD, WAIT_SOLVE and WAIT_BKT and increments each cycle in them.
  - When it reaches TIMEOUT_CYCLES: timeout_o=1, sat_o=unsat_o=0 → FINISH.
- Undefined: no counter; timeout_o is constant 0.

Decomposition:
- Shared package sat_bin_pkg holds:
  - bin_result encodings (RES_SAT=0, RES_CONFLICT=1, RES_UNSAT=2);
  - scheduler state encoding;
  - WIDTH_BIN_I and WIDTH_LVL defaults.
- No sub-module; the watchdog counter stays inline under the macro.

Test Plan:
1. NUM_BINS=4, start_i, engine returns result 0 each bin → request_bin_num_o 0,1,2,3; first_load_update_o only with bin 0; one done_o; sat_o=1; conflict_cnt_o=0.
2. Conflict at bin 2, bkt_lvl_i=5, bkt_bin_i=1 → one start_backtrack_o with bkt_lvl_o=5; after backtrack_done_i next request_bin_num_o=1; conflict_cnt_o=1.
3. Conflict at bin 1 with bkt_bin_i=3 → next load is bin 1 (clamped).
4. Conflict with bkt_lvl_i=0 → unsat_o=1, done_o pulse, start_backtrack_o never asserted; result 2 at bin 0 → unsat_o=1.
5. rst=0 during WAIT_SOLVE for 1 cycle → all outputs 0 next cycle; stray bin_solve_done_i ignored; new start_i restarts at bin 0 with first_load_update_o=1.
6. With BIN_SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=16, load_update_done_i held 0 → done_o pulse 16 cycles after WAIT_LOAD entry; timeout_o=1; sat_o=unsat_o=0.

Source files
------------

// File: rtl/sat_bin_pkg.sv
// ---------------------------------------------------------------------------
// sat_bin_pkg
//
// Shared definitions for the bin-level SAT solving pipeline.
//
// Contents:
//   DEF_WIDTH_BIN_I : default bin index width
//   DEF_WIDTH_LVL   : default decision level width
//   bin_result_e    : per-bin result encoding returned by the bin SAT engine
//   sched_state_e   : bin scheduler FSM state encoding
// ---------------------------------------------------------------------------
package sat_bin_pkg;

    // Default widths used by every block that carries bin indices or levels
    localparam int DEF_WIDTH_BIN_I = 10;
    localparam int DEF_WIDTH_LVL   = 10;

    // Result reported by the bin SAT engine. The reserved code is handled
    // exactly like a global UNSAT by consumers.
    typedef enum logic [1:0] {
        RES_SAT      = 2'd0,
        RES_CONFLICT = 2'd1,
        RES_UNSAT    = 2'd2,
        RES_RSVD     = 2'd3
    } bin_result_e;

    // Bin scheduler states: each request state (LOAD/SOLVE/BKT) emits a
    // single-cycle start pulse and is followed by a matching wait state.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        WAIT_LOAD  = 3'd2,
        SOLVE      = 3'd3,
        WAIT_SOLVE = 3'd4,
        BKT        = 3'd5,
        WAIT_BKT   = 3'd6,
        FINISH     = 3'd7
    } sched_state_e;

endpackage

// File: rtl/bin_scheduler.sv
// ---------------------------------------------------------------------------
// bin_scheduler
//
// Top-level bin sequencing controller sitting directly upstream of the bin
// load/update stage. It walks the bins of the problem image in order,
// launching a load/update and then a bin solve for each one. On a conflict
// it starts a global variable-state backtrack and resumes at the backtrack
// bin; it finally reports SAT or UNSAT.
//
// Optional feature (macro BIN_SCHED_WATCHDOG_EN):
//   A per-wait-state watchdog. When a handshake does not arrive within
//   TIMEOUT_CYCLES cycles the run ends with timeout_o=1 and neither SAT nor
//   UNSAT. Without the macro there is no counter and timeout_o is tied 0.
//
// Ports:
//   clk                  clock
//   rst                  synchronous, active-low reset
//   start_i              pulse: begin solving from bin 0
//   start_load_update_o  one-cycle pulse to the load/update stage
//   first_load_update_o  marks the first load after start_i (no write-back)
//   request_bin_num_o    bin to load, stable until load_update_done_i
//   load_update_done_i   load/update stage finished
//   start_bin_solve_o    one-cycle pulse to the bin SAT engine
//   bin_solve_done_i     engine result valid (single cycle)
//   bin_result_i         0=SAT, 1=conflict, 2=global UNSAT, 3=as 2
//   bkt_lvl_i            backtrack level, sampled with bin_solve_done_i
//   bkt_bin_i            resume bin, sampled with bin_solve_done_i
//   start_backtrack_o    one-cycle pulse to the backtrack engine
//   bkt_lvl_o            captured backtrack level
//   backtrack_done_i     backtrack finished
//   busy_o               scheduler not idle
//   done_o               one-cycle pulse when the run finishes
//   sat_o / unsat_o      final verdict, held until next start_i
//   conflict_cnt_o       conflicts since start_i, saturating
//   timeout_o            watchdog fired, held until next start_i
// ---------------------------------------------------------------------------
module bin_scheduler
    import sat_bin_pkg::*;
#(
    parameter int NUM_BINS       = 32,
    parameter int WIDTH_BIN_I    = DEF_WIDTH_BIN_I,
    parameter int WIDTH_LVL      = DEF_WIDTH_LVL,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   start_load_update_o,
    output logic                   first_load_update_o,
    output logic [WIDTH_BIN_I-1:0] request_bin_num_o,
    input  logic                   load_update_done_i,
    output logic                   start_bin_solve_o,
    input  logic                   bin_solve_done_i,
    input  logic [1:0]             bin_result_i,
    input  logic [WIDTH_LVL-1:0]   bkt_lvl_i,
    input  logic [WIDTH_BIN_I-1:0] bkt_bin_i,
    output logic                   start_backtrack_o,
    output logic [WIDTH_LVL-1:0]   bkt_lvl_o,
    input  logic                   backtrack_done_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   sat_o,
    output logic                   unsat_o,
    output logic [31:0]            conflict_cnt_o,
    output logic                   timeout_o
);

    localparam logic [WIDTH_BIN_I-1:0] LAST_BIN = WIDTH_BIN_I'(NUM_BINS - 1);

    sched_state_e           state_q, state_d;
    logic [WIDTH_BIN_I-1:0] curBin_q, curBin_d;
    logic [WIDTH_BIN_I-1:0] target_q, target_d;
    logic                   first_q, first_d;
    logic [WIDTH_LVL-1:0]   bktLvl_q, bktLvl_d;
    logic                   sat_q, sat_d;
    logic                   unsat_q, unsat_d;
    logic [31:0]            conflictCnt_q, conflictCnt_d;
    logic                   wdFire;
    bin_result_e            result;

    assign result = bin_result_e'(bin_result_i);

`ifdef BIN_SCHED_WATCHDOG_EN
    // Watchdog: counts cycles spent in the current wait state. It restarts
    // at zero whenever a wait state is entered (the request states always
    // precede a wait state and hold it at zero) and fires on the cycle that
    // would bring it to TIMEOUT_CYCLES, so a stalled wait state lasts
    // exactly TIMEOUT_CYCLES cycles before FINISH. A handshake arriving in
    // the firing cycle takes precedence.
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wdCnt_q, wdCnt_d;
    logic        timeout_q, timeout_d;
    logic        inWait;
    logic        handshake;

    assign inWait    = (state_q == WAIT_LOAD) || (state_q == WAIT_SOLVE) ||
                       (state_q == WAIT_BKT);
    assign handshake = ((state_q == WAIT_LOAD)  && load_update_done_i) ||
                       ((state_q == WAIT_SOLVE) && bin_solve_done_i)   ||
                       ((state_q == WAIT_BKT)   && backtrack_done_i);
    assign wdFire    = inWait && !handshake && (wdCnt_q == WD_LAST);

    always_comb begin
        wdCnt_d   = '0;
        timeout_d = timeout_q;
        if (inWait && !handshake) begin
            wdCnt_d = wdCnt_q + 32'd1;
        end
        if ((state_q == IDLE) && start_i) begin
            timeout_d = 1'b0;
        end
        if (wdFire) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdCnt_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdCnt_q   <= wdCnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wdFire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Next-state and datapath logic. Each handshake input is only looked at
    // in its own wait state, so early or stray completions are dropped.
    always_comb begin
        state_d       = state_q;
        curBin_d      = curBin_q;
        target_d      = target_q;
        first_d       = first_q;
        bktLvl_d      = bktLvl_q;
        sat_d         = sat_q;
        unsat_d       = unsat_q;
        conflictCnt_d = conflictCnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d       = LOAD;
                    curBin_d      = '0;
                    first_d       = 1'b1;
                    sat_d         = 1'b0;
                    unsat_d       = 1'b0;
                    conflictCnt_d = '0;
                end
            end
            LOAD: begin
                first_d = 1'b0;
                state_d = WAIT_LOAD;
            end
            WAIT_LOAD: begin
                if (load_update_done_i) begin
                    state_d = SOLVE;
                end
            end
            SOLVE: begin
                state_d = WAIT_SOLVE;
            end
            WAIT_SOLVE: begin
                if (bin_solve_done_i) begin
                    case (result)
                        RES_SAT: begin
                            if (curBin_q == LAST_BIN) begin
                                sat_d   = 1'b1;
                                state_d = FINISH;
                            end else begin
                                curBin_d = curBin_q + 1'b1;
                                state_d  = LOAD;
                            end
                        end
                        RES_CONFLICT: begin
                            if (conflictCnt_q != '1) begin
                                conflictCnt_d = conflictCnt_q + 32'd1;
                            end
                            // A conflict at level 0 cannot be undone.
                            if (bkt_lvl_i == '0) begin
                                unsat_d = 1'b1;
                                state_d = FINISH;
                            end else begin
                                // Never resume past the bin that conflicted.
                                bktLvl_d = bkt_lvl_i;
                                target_d = (bkt_bin_i < curBin_q) ? bkt_bin_i : curBin_q;
                                state_d  = BKT;
                            end
                        end
                        default: begin
                            unsat_d = 1'b1;
                            state_d = FINISH;
                        end
                    endcase
                end
            end
            BKT: begin
                state_d = WAIT_BKT;
            end
            WAIT_BKT: begin
                if (backtrack_done_i) begin
                    curBin_d = target_q;
                    state_d  = LOAD;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wdFire) begin
            sat_d   = 1'b0;
            unsat_d = 1'b0;
            state_d = FINISH;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            curBin_q      <= '0;
            target_q      <= '0;
            first_q       <= 1'b0;
            bktLvl_q      <= '0;
            sat_q         <= 1'b0;
            unsat_q       <= 1'b0;
            conflictCnt_q <= '0;
        end else begin
            state_q       <= state_d;
            curBin_q      <= curBin_d;
            target_q      <= target_d;
            first_q       <= first_d;
            bktLvl_q      <= bktLvl_d;
            sat_q         <= sat_d;
            unsat_q       <= unsat_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    // Pulses are decoded from the state register, so each lasts exactly one
    // cycle and none can appear in the cycle following a reset.
    assign start_load_update_o = (state_q == LOAD);
    assign first_load_update_o = (state_q == LOAD) && first_q;
    assign start_bin_solve_o   = (state_q == SOLVE);
    assign start_backtrack_o   = (state_q == BKT);
    assign done_o              = (state_q == FINISH);
    assign busy_o              = (state_q != IDLE);
    assign request_bin_num_o   = curBin_q;
    assign bkt_lvl_o           = bktLvl_q;
    assign sat_o               = sat_q;
    assign unsat_o             = unsat_q;
    assign conflict_cnt_o      = conflictCnt_q;

endmodule

// File: tb/tb_bin_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bin_scheduler
//
// Directed bench for bin_scheduler with NUM_BINS=4. Expected load requests
// and backtrack levels are queued as the stimulus is planned and consumed by
// a monitor as the scheduler emits its pulses. When compiled with
// BIN_SCHED_WATCHDOG_EN the timeout path is exercised with TIMEOUT_CYCLES=16.
// ---------------------------------------------------------------------------
module tb_bin_scheduler;

    localparam int NB   = 4;
    localparam int WB   = 10;
    localparam int WL   = 10;
    localparam int TOUT = 16;

    localparam int SEL_LOAD  = 0;
    localparam int SEL_SOLVE = 1;
    localparam int SEL_BKT   = 2;
    localparam int SEL_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          start_load_update_o;
    logic          first_load_update_o;
    logic [WB-1:0] request_bin_num_o;
    logic          load_update_done_i = 1'b0;
    logic          start_bin_solve_o;
    logic          bin_solve_done_i = 1'b0;
    logic [1:0]    bin_result_i = 2'd0;
    logic [WL-1:0] bkt_lvl_i = '0;
    logic [WB-1:0] bkt_bin_i = '0;
    logic          start_backtrack_o;
    logic [WL-1:0] bkt_lvl_o;
    logic          backtrack_done_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          sat_o;
    logic          unsat_o;
    logic [31:0]   conflict_cnt_o;
    logic          timeout_o;

    typedef struct {
        logic [WB-1:0] bin;
        logic          first;
    } loadExp_t;

    loadExp_t loadQ[$];
    int       bktQ[$];
    int       checks  = 0;
    int       errors  = 0;
    int       doneCnt = 0;

    bin_scheduler #(
        .NUM_BINS       (NB),
        .WIDTH_BIN_I    (WB),
        .WIDTH_LVL      (WL),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .start_load_update_o (start_load_update_o),
        .first_load_update_o (first_load_update_o),
        .request_bin_num_o   (request_bin_num_o),
        .load_update_done_i  (load_update_done_i),
        .start_bin_solve_o   (start_bin_solve_o),
        .bin_solve_done_i    (bin_solve_done_i),
        .bin_result_i        (bin_result_i),
        .bkt_lvl_i           (bkt_lvl_i),
        .bkt_bin_i           (bkt_bin_i),
        .start_backtrack_o   (start_backtrack_o),
        .bkt_lvl_o           (bkt_lvl_o),
        .backtrack_done_i    (backtrack_done_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .sat_o               (sat_o),
        .unsat_o             (unsat_o),
        .conflict_cnt_o      (conflict_cnt_o),
        .timeout_o           (timeout_o)
    );

    // Free-running clock; all driving and sampling happens on the falling edge.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic sigSel(input int sel);
        case (sel)
            SEL_LOAD:  return start_load_update_o;
            SEL_SOLVE: return start_bin_solve_o;
            SEL_BKT:   return start_backtrack_o;
            default:   return done_o;
        endcase
    endfunction

    // Bounded wait for a scheduler pulse; an expired budget is a failed check.
    task automatic waitFor(input int sel, input string tag);
        int n;
        n = 0;
        while (sigSel(sel) !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(sigSel(sel)), 32'd1);
    endtask

    task automatic applyStimulus();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic pushLoad(input int bin, input logic first);
        loadExp_t e;
        e.bin   = WB'(bin);
        e.first = first;
        loadQ.push_back(e);
    endtask

    // Serves one bin: completes its load, then returns the given result.
    task automatic serviceBin(input logic [1:0] res, input int lvl, input int bin);
        waitFor(SEL_LOAD, "loadPulse");
        @(negedge clk);
        load_update_done_i = 1'b1;
        @(negedge clk);
        load_update_done_i = 1'b0;
        waitFor(SEL_SOLVE, "solvePulse");
        @(negedge clk);
        bin_solve_done_i = 1'b1;
        bin_result_i     = res;
        bkt_lvl_i        = WL'(lvl);
        bkt_bin_i        = WB'(bin);
        @(negedge clk);
        bin_solve_done_i = 1'b0;
        bin_result_i     = 2'd0;
    endtask

    task automatic serviceBkt(input int expLvl, input int delay);
        waitFor(SEL_BKT, "bktPulse");
        @(negedge clk);
        repeat (delay) @(negedge clk);
        checkOutput("bktLvlHeld", 32'(bkt_lvl_o), 32'(expLvl));
        backtrack_done_i = 1'b1;
        @(negedge clk);
        backtrack_done_i = 1'b0;
    endtask

    task automatic checkFinish(input logic expSat, input logic expUnsat, input int expCnt);
        waitFor(SEL_DONE, "donePulse");
        checkOutput("sat", 32'(sat_o), 32'(expSat));
        checkOutput("unsat", 32'(unsat_o), 32'(expUnsat));
        checkOutput("conflictCnt", conflict_cnt_o, 32'(expCnt));
        checkOutput("timeout", 32'(timeout_o), 32'd0);
        @(negedge clk);
        checkOutput("doneOneCycle", 32'(done_o), 32'd0);
        checkOutput("idleAfterDone", 32'(busy_o), 32'd0);
        checkOutput("satHeld", 32'(sat_o), 32'(expSat));
        checkOutput("queueDrained", 32'(loadQ.size() + bktQ.size()), 32'd0);
    endtask

    // Monitor: every load or backtrack pulse must match the next queued
    // expectation; unplanned pulses are reported as failures.
    always @(negedge clk) begin
        if (start_load_update_o) begin
            if (loadQ.size() == 0) begin
                checkOutput("unexpectedLoad", 32'(loadQ.size()), 32'd1);
            end else begin
                loadExp_t e;
                e = loadQ.pop_front();
                checkOutput("loadBin", 32'(request_bin_num_o), 32'(e.bin));
                checkOutput("loadFirst", 32'(first_load_update_o), 32'(e.first));
            end
        end else if (first_load_update_o) begin
            checkOutput("firstWithoutPulse", 32'(first_load_update_o), 32'd0);
        end
        if (start_backtrack_o) begin
            if (bktQ.size() == 0) begin
                checkOutput("unexpectedBkt", 32'(bktQ.size()), 32'd1);
            end else begin
                checkOutput("bktLvl", 32'(bkt_lvl_o), 32'(bktQ.pop_front()));
            end
        end
        if (done_o) doneCnt++;
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", 32'(busy_o), 32'd0);
        checkOutput("rstOutputs", {24'd0, start_load_update_o, first_load_update_o,
                    start_bin_solve_o, start_backtrack_o, done_o, sat_o, unsat_o,
                    timeout_o}, 32'd0);
        checkOutput("rstReqBin", 32'(request_bin_num_o), 32'd0);
        checkOutput("rstCnt", conflict_cnt_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: every bin satisfiable
        $display("[TB] scenario 1: all bins SAT");
        pushLoad(0, 1'b1); pushLoad(1, 1'b0); pushLoad(2, 1'b0); pushLoad(3, 1'b0);
        applyStimulus();
        checkOutput("busyAfterStart", 32'(busy_o), 32'd1);
        for (int b = 0; b < NB; b++) serviceBin(2'd0, 0, 0);
        checkFinish(1'b1, 1'b0, 0);
        repeat (3) @(negedge clk);
        checkOutput("oneDone", 32'(doneCnt), 32'd1);

        // 2: conflict at bin 2 backtracks to bin 1
        $display("[TB] scenario 2: conflict with backtrack");
        pushLoad(0, 1'b1); pushLoad(1, 1'b0); pushLoad(2, 1'b0);
        applyStimulus();
        checkOutput("satClearedOnStart", 32'(sat_o), 32'd0);
        serviceBin(2'd0, 0, 0);
        serviceBin(2'd0, 0, 0);
        bktQ.push_back(5);
        serviceBin(2'd1, 5, 1);
        checkOutput("cntAfterConflict", conflict_cnt_o, 32'd1);
        pushLoad(1, 1'b0); pushLoad(2, 1'b0); pushLoad(3, 1'b0);
        serviceBkt(5, 3);
        for (int b = 1; b < NB; b++) serviceBin(2'd0, 0, 0);
        checkFinish(1'b1, 1'b0, 1);

        // 3: resume bin clamped to the conflicting bin, then global UNSAT
        $display("[TB] scenario 3: clamped backtrack bin");
        pushLoad(0, 1'b1); pushLoad(1, 1'b0);
        applyStimulus();
        serviceBin(2'd0, 0, 0);
        bktQ.push_back(2);
        serviceBin(2'd1, 2, 3);
        pushLoad(1, 1'b0);
        serviceBkt(2, 0);
        serviceBin(2'd2, 0, 0);
        checkFinish(1'b0, 1'b1, 1);

        // 4: level-0 conflict, result 2 and reserved result 3
        $display("[TB] scenario 4: UNSAT paths");
        pushLoad(0, 1'b1);
        applyStimulus();
        checkOutput("unsatClearedOnStart", 32'(unsat_o), 32'd0);
        serviceBin(2'd1, 0, 0);
        checkFinish(1'b0, 1'b1, 1);
        pushLoad(0, 1'b1);
        applyStimulus();
        serviceBin(2'd2, 0, 0);
        checkFinish(1'b0, 1'b1, 0);
        pushLoad(0, 1'b1);
        applyStimulus();
        serviceBin(2'd3, 0, 0);
        checkFinish(1'b0, 1'b1, 0);

        // 5: reset while waiting for a solve result
        $display("[TB] scenario 5: mid-run reset");
        pushLoad(0, 1'b1); pushLoad(1, 1'b0);
        applyStimulus();
        serviceBin(2'd0, 0, 0);
        waitFor(SEL_LOAD, "loadPulse");
        @(negedge clk);
        load_update_done_i = 1'b1;
        @(negedge clk);
        load_update_done_i = 1'b0;
        waitFor(SEL_SOLVE, "solvePulse");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("abortOutputs", {22'd0, busy_o, start_load_update_o,
                    first_load_update_o, start_bin_solve_o, start_backtrack_o,
                    done_o, sat_o, unsat_o, timeout_o, |request_bin_num_o}, 32'd0);
        checkOutput("abortBktLvl", 32'(bkt_lvl_o), 32'd0);
        checkOutput("abortCnt", conflict_cnt_o, 32'd0);
        bin_solve_done_i = 1'b1;
        @(negedge clk);
        bin_solve_done_i = 1'b0;
        @(negedge clk);
        checkOutput("strayDoneIgnored", {30'd0, busy_o, sat_o}, 32'd0);
        for (int b = 0; b < NB; b++) pushLoad(b, b == 0);
        applyStimulus();
        for (int b = 0; b < NB; b++) serviceBin(2'd0, 0, 0);
        checkFinish(1'b1, 1'b0, 0);

        // 6: stalled load/update stage
        $display("[TB] scenario 6: stalled load");
        pushLoad(0, 1'b1);
        applyStimulus();
        waitFor(SEL_LOAD, "loadPulse");
`ifdef BIN_SCHED_WATCHDOG_EN
        begin
            int n;
            n = 0;
            @(negedge clk);
            n = 1;
            while (!done_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            checkOutput("timeoutLatency", 32'(n), 32'(TOUT + 1));
            checkOutput("timeoutFlag", 32'(timeout_o), 32'd1);
            checkOutput("timeoutVerdict", {30'd0, sat_o, unsat_o}, 32'd0);
            @(negedge clk);
            checkOutput("timeoutHeld", 32'(timeout_o), 32'd1);
        end
`else
        repeat (40) @(negedge clk);
        checkOutput("stallBusy", 32'(busy_o), 32'd1);
        checkOutput("stallNoTimeout", {30'd0, timeout_o, done_o}, 32'd0);
        @(negedge clk);
        load_update_done_i = 1'b1;
        @(negedge clk);
        load_update_done_i = 1'b0;
        waitFor(SEL_SOLVE, "solvePulse");
        @(negedge clk);
        bin_solve_done_i = 1'b1;
        bin_result_i     = 2'd2;
        @(negedge clk);
        bin_solve_done_i = 1'b0;
        bin_result_i     = 2'd0;
        checkFinish(1'b0, 1'b1, 0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
